// File: rtl/box_h_stream_fp.sv
// Horizontal box filter over a raster floating-point stream: forms its own
// WINDOW_WIDTH-tap window with zero/replicate edges, sums it through a pipelined
// FP adder tree and scales the result by 2^-scale_i.

module box_h_stream_fp_add #(
    parameter int EXP_WIDTH  = 5,
    parameter int FRAC_WIDTH = 10,
    parameter int LAT        = 1,
    parameter int FPW        = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [FPW-1:0] a_i,
    input  logic [FPW-1:0] b_i,
    output logic [FPW-1:0] sum_o
);
    localparam int MW = FRAC_WIDTH + 4;  // hidden + fraction + guard/round/sticky
    localparam logic [EXP_WIDTH-1:0]  EMAX  = '1;
    localparam logic [FRAC_WIDTH-1:0] QFRAC = FRAC_WIDTH'(1) << (FRAC_WIDTH - 1);

    // Round-to-nearest-even add; subnormal inputs and results flush to zero.
    function automatic logic [FPW-1:0] fp_add(input logic [FPW-1:0] a, input logic [FPW-1:0] b);
        logic [FPW-1:0]        x, y;
        logic                  sx, sy, sticky, up;
        logic [EXP_WIDTH-1:0]  ea, eb, ex, ey;
        logic [MW-1:0]         mx, my, mr;
        logic [MW:0]           acc;
        logic [FRAC_WIDTH+1:0] rnd;
        int                    d, er, lz;
        ea = a[FPW-2:FRAC_WIDTH];
        eb = b[FPW-2:FRAC_WIDTH];
        if (ea == EMAX || eb == EMAX) begin
            if ((ea == EMAX && a[FRAC_WIDTH-1:0] != '0) || (eb == EMAX && b[FRAC_WIDTH-1:0] != '0) ||
                (ea == EMAX && eb == EMAX && a[FPW-1] != b[FPW-1]))
                return {1'b0, EMAX, QFRAC};
            return (ea == EMAX) ? a : b;
        end
        if (ea == '0 && eb == '0) return {a[FPW-1] & b[FPW-1], {(FPW-1){1'b0}}};
        if (ea == '0) return b;
        if (eb == '0) return a;
        if (b[FPW-2:0] > a[FPW-2:0]) begin x = b; y = a; end
        else begin x = a; y = b; end
        sx = x[FPW-1];
        sy = y[FPW-1];
        ex = x[FPW-2:FRAC_WIDTH];
        ey = y[FPW-2:FRAC_WIDTH];
        mx = {1'b1, x[FRAC_WIDTH-1:0], 3'b000};
        my = {1'b1, y[FRAC_WIDTH-1:0], 3'b000};
        d = int'(ex) - int'(ey);
        sticky = 1'b0;
        for (int i = 0; i < MW; i++) if (i < d) sticky = sticky | my[i];
        my = my >> d;
        my[0] = my[0] | sticky;
        er = int'(ex);
        if (sx == sy) begin
            acc = {1'b0, mx} + {1'b0, my};
            if (acc[MW]) begin
                acc = {1'b0, acc[MW:2], acc[1] | acc[0]};
                er = er + 1;
            end
        end else begin
            acc = {1'b0, mx} - {1'b0, my};
            if (acc == '0) return '0;
            lz = 0;
            for (int i = 0; i < MW; i++) if (acc[i]) lz = MW - 1 - i;
            acc = acc << lz;
            er = er - lz;
        end
        mr  = acc[MW-1:0];
        up  = mr[2] & (mr[1] | mr[0] | mr[3]);
        rnd = {1'b0, mr[MW-1:3]} + {{(FRAC_WIDTH+1){1'b0}}, up};
        if (rnd[FRAC_WIDTH+1]) begin
            rnd = rnd >> 1;
            er  = er + 1;
        end
        if (er <= 0) return {sx, {(FPW-1){1'b0}}};
        if (er >= int'(EMAX)) return {sx, EMAX, {FRAC_WIDTH{1'b0}}};
        return {sx, EXP_WIDTH'(er), rnd[FRAC_WIDTH-1:0]};
    endfunction

    logic [FPW-1:0] sum_c;
    assign sum_c = fp_add(a_i, b_i);

    generate
        if (LAT == 0) begin : g_comb
            assign sum_o = sum_c;
        end else begin : g_pipe
            logic [LAT-1:0][FPW-1:0] pipe_q;
            always_ff @(posedge clk_i) begin
                if (rst_i) pipe_q <= '0;
                else begin
                    pipe_q[0] <= sum_c;
                    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign sum_o = pipe_q[LAT-1];
        end
    endgenerate
endmodule

module box_h_stream_fp #(
    parameter  int EXP_WIDTH       = 5,
    parameter  int FRAC_WIDTH      = 10,
    parameter  int WINDOW_WIDTH    = 3,
    parameter  int ADD_LATENCY     = 1,
    parameter  int MAX_SCALE_WIDTH = 4,
    localparam int FP_WIDTH        = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [FP_WIDTH-1:0]        data_i,
    input  logic [15:0]                col_i,
    input  logic [15:0]                row_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [15:0]                width_i,
    input  logic                       edge_mode_i,
    input  logic [MAX_SCALE_WIDTH-1:0] scale_i,
    output logic [FP_WIDTH-1:0]        data_o,
    output logic [15:0]                col_o,
    output logic [15:0]                row_o,
    output logic                       valid_o
);
    localparam int R        = (WINDOW_WIDTH - 1) / 2;
    localparam int LEVELS   = $clog2(WINDOW_WIDTH);
    localparam int N        = 1 << LEVELS;
    localparam int TREE_LAT = LEVELS * ADD_LATENCY;
    localparam logic [15:0] R16 = 16'(R);

    typedef enum logic {ACCEPT, FLUSH} state_t;
    typedef struct packed {
        logic        vld;
        logic [15:0] col;
        logic [15:0] row;
    } meta_t;

    state_t state_q, state_d;
    logic [WINDOW_WIDTH-1:0][FP_WIDTH-1:0] win_q, win_d, taps;
    logic [15:0] width_q, width_d, row_q, row_d, cnt_q, cnt_d, sh_q, sh_d, fcol_q, fcol_d;
    logic        edge_q, edge_d, in_row_q, in_row_d;
    logic [15:0] width_eff, flush_len;
    logic        beat, last_beat, flushing;
    meta_t       meta_in, meta_out;

    // A beat outside a started row (e.g. right after reset) is consumed but ignored.
    assign beat      = valid_i & ready_o & ((col_i == 16'd0) | in_row_q);
    assign width_eff = (col_i == 16'd0) ? width_i : width_q;
    assign last_beat = beat & (col_i == width_eff - 16'd1);
    assign flush_len = (width_eff < R16) ? width_eff : R16;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ACCEPT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCEPT:  if (last_beat && R > 0) state_d = FLUSH;
            FLUSH:   if (cnt_q == 16'd1) state_d = ACCEPT;
            default: state_d = ACCEPT;
        endcase
    end

    always_comb begin
        ready_o  = 1'b0;
        flushing = 1'b0;
        case (state_q)
            ACCEPT:  ready_o  = 1'b1;
            FLUSH:   flushing = 1'b1;
            default: ready_o  = 1'b1;
        endcase
    end

    // The window holds the last WINDOW_WIDTH columns, newest at the top; a row start
    // pre-fills the left side with the edge value. During flush the frozen window is
    // viewed shifted by sh_q columns, filling past the right edge.
    always_comb begin
        win_d    = win_q;
        width_d  = width_q;
        edge_d   = edge_q;
        in_row_d = in_row_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        fcol_d   = fcol_q;
        taps     = win_q;
        meta_in  = '{vld: 1'b0, col: 16'd0, row: row_q};
        if (beat) begin
            if (col_i == 16'd0) begin
                width_d  = width_i;
                edge_d   = edge_mode_i;
                in_row_d = 1'b1;
                for (int t = 0; t < WINDOW_WIDTH - 1; t++) win_d[t] = edge_mode_i ? data_i : '0;
            end else begin
                for (int t = 0; t < WINDOW_WIDTH - 1; t++) win_d[t] = win_q[t+1];
            end
            win_d[WINDOW_WIDTH-1] = data_i;
            row_d   = row_i;
            taps    = win_d;
            meta_in = '{vld: (col_i >= R16), col: col_i - R16, row: row_i};
            if (last_beat) begin
                in_row_d = 1'b0;
                cnt_d    = flush_len;
                sh_d     = R16 - flush_len + 16'd1;
                fcol_d   = width_eff - flush_len;
            end
        end else if (flushing) begin
            for (int t = 0; t < WINDOW_WIDTH; t++) begin
                taps[t] = edge_q ? win_q[WINDOW_WIDTH-1] : '0;
                for (int s = 0; s < WINDOW_WIDTH; s++)
                    if (32'(t) + 32'(sh_q) == 32'(s)) taps[t] = win_q[s];
            end
            meta_in = '{vld: 1'b1, col: fcol_q, row: row_q};
            cnt_d   = cnt_q - 16'd1;
            sh_d    = sh_q + 16'd1;
            fcol_d  = fcol_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_q    <= '0;
            width_q  <= '0;
            edge_q   <= 1'b0;
            in_row_q <= 1'b0;
            row_q    <= '0;
            cnt_q    <= '0;
            sh_q     <= '0;
            fcol_q   <= '0;
        end else begin
            win_q    <= win_d;
            width_q  <= width_d;
            edge_q   <= edge_d;
            in_row_q <= in_row_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            fcol_q   <= fcol_d;
        end
    end

    // Heap-ordered tree: node j sums nodes 2j+1 and 2j+2, leaves start at N-1.
    logic [FP_WIDTH-1:0] node [2*N-1];
    generate
        for (genvar i = 0; i < N; i++) begin : g_leaf
            if (i < WINDOW_WIDTH) begin : g_tap
                assign node[N-1+i] = taps[i];
            end else begin : g_pad
                assign node[N-1+i] = '0;
            end
        end
        for (genvar j = 0; j < N - 1; j++) begin : g_add
            box_h_stream_fp_add #(
                .EXP_WIDTH (EXP_WIDTH),
                .FRAC_WIDTH(FRAC_WIDTH),
                .LAT       (ADD_LATENCY)
            ) u_add (
                .clk_i(clk_i),
                .rst_i(rst_i),
                .a_i  (node[2*j+1]),
                .b_i  (node[2*j+2]),
                .sum_o(node[j])
            );
        end
        if (TREE_LAT == 0) begin : g_nometa
            assign meta_out = meta_in;
        end else begin : g_meta
            meta_t [TREE_LAT-1:0] meta_q;
            always_ff @(posedge clk_i) begin
                if (rst_i) meta_q <= '0;
                else begin
                    meta_q[0] <= meta_in;
                    for (int i = 1; i < TREE_LAT; i++) meta_q[i] <= meta_q[i-1];
                end
            end
            assign meta_out = meta_q[TREE_LAT-1];
        end
    endgenerate

    logic [FP_WIDTH-1:0]  sum_w, data_d, data_q;
    logic [EXP_WIDTH-1:0] sum_e;
    logic [15:0]          col_q, row_oq;
    logic                 valid_q;
    assign sum_w = node[0];
    assign sum_e = sum_w[FP_WIDTH-2:FRAC_WIDTH];

    always_comb begin
        data_d = sum_w;
        if (sum_e == '1 || sum_w[FP_WIDTH-2:0] == '0)
            data_d = sum_w;
        else if (int'(sum_e) <= int'(scale_i))
            data_d = {sum_w[FP_WIDTH-1], {(FP_WIDTH-1){1'b0}}};
        else
            data_d = {sum_w[FP_WIDTH-1], EXP_WIDTH'(int'(sum_e) - int'(scale_i)),
                      sum_w[FRAC_WIDTH-1:0]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            col_q   <= '0;
            row_oq  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            col_q   <= meta_out.col;
            row_oq  <= meta_out.row;
            valid_q <= meta_out.vld;
        end
    end

    assign data_o  = data_q;
    assign col_o   = col_q;
    assign row_o   = row_oq;
    assign valid_o = valid_q;
endmodule

// File: tb/tb_box_h_stream_fp.sv
// Directed bench for box_h_stream_fp: a 3-tap and a 5-tap instance share stimulus,
// one is selected at a time; outputs are logged and checked against hand values.

module tb_box_h_stream_fp;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] data_i = '0, col_i = '0, row_i = '0, width_i = 16'd4;
    logic        valid_i = 1'b0, edge_mode_i = 1'b0, sel5 = 1'b0;
    logic [3:0]  scale_i = '0;

    logic        v3, v5, r3, r5, vo3, vo5;
    logic [15:0] d3, d5, c3, c5, w3, w5;
    assign v3 = valid_i & ~sel5;
    assign v5 = valid_i & sel5;

    box_h_stream_fp #(.WINDOW_WIDTH(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .col_i(col_i), .row_i(row_i),
        .valid_i(v3), .ready_o(r3), .width_i(width_i), .edge_mode_i(edge_mode_i),
        .scale_i(scale_i), .data_o(d3), .col_o(c3), .row_o(w3), .valid_o(vo3));

    box_h_stream_fp #(.WINDOW_WIDTH(5)) u_dut5 (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .col_i(col_i), .row_i(row_i),
        .valid_i(v5), .ready_o(r5), .width_i(width_i), .edge_mode_i(edge_mode_i),
        .scale_i(scale_i), .data_o(d5), .col_o(c5), .row_o(w5), .valid_o(vo5));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rdy, vsel;
    logic [15:0] dsel, csel, wsel;
    assign rdy  = sel5 ? r5 : r3;
    assign vsel = sel5 ? vo5 : vo3;
    assign dsel = sel5 ? d5 : d3;
    assign csel = sel5 ? c5 : c3;
    assign wsel = sel5 ? w5 : w3;

    logic [15:0] got_d [64];
    logic [15:0] got_c [64];
    logic [15:0] got_r [64];
    int          got_cyc [64];
    int          n_out = 0, rlow = 0, acc_cyc = 0, errors = 0, checks = 0;

    always @(negedge clk) begin
        if (!rst_i) begin
            if (!rdy) rlow = rlow + 1;
            if (vsel && n_out < 64) begin
                got_d[n_out]   = dsel;
                got_c[n_out]   = csel;
                got_r[n_out]   = wsel;
                got_cyc[n_out] = cyc;
                n_out = n_out + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] r, input logic [15:0] c, input logic [15:0] d);
        int g;
        row_i = r; col_i = c; data_i = d; valid_i = 1'b1;
        g = 0;
        @(negedge clk);
        while (!rdy && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk($sformatf("ready_wait_r%0d_c%0d", r, c), 32'(g < 20), 32'd1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        acc_cyc = cyc - 1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        n_out = 0;
        rlow  = 0;
    endtask

    logic [15:0] exp_zero4 [4] = '{16'h4000, 16'h4200, 16'h4200, 16'h4000};
    logic [15:0] exp_w5 [5]    = '{16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00, 16'h4200};
    logic [15:0] px_w5 [5]     = '{16'h3C00, 16'h7C00, 16'h3C00, 16'h3C00, 16'h3C00};
    int          last_acc;

    initial begin
        idle(3);
        rst_i = 1'b0;
        @(negedge clk);
        chk("reset_data", 32'(d3), 32'h0);
        chk("reset_col", 32'(c3), 32'h0);
        chk("reset_row", 32'(w3), 32'h0);
        chk("reset_valid", 32'(vo3), 32'h0);
        chk("reset_ready", 32'(r3), 32'h1);
        idle(1);

        // zero pad, width 4, row of 1.0
        clear_log();
        width_i = 16'd4; edge_mode_i = 1'b0; scale_i = 4'd0;
        for (int c = 0; c < 4; c++) send(16'd0, 16'(c), 16'h3C00);
        last_acc = acc_cyc;
        idle(8);
        chk("zero_count", 32'(n_out), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("zero_data%0d", i), 32'(got_d[i]), 32'(exp_zero4[i]));
            chk($sformatf("zero_col%0d", i), 32'(got_c[i]), 32'(i));
        end
        chk("zero_ready_low", 32'(rlow), 32'd1);
        chk("zero_latency", 32'(got_cyc[2] - last_acc), 32'd3);
        chk("zero_flush_next", 32'(got_cyc[3] - got_cyc[2]), 32'd1);

        // replicate, two back-to-back rows
        clear_log();
        edge_mode_i = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) send(16'(r), 16'(c), 16'h3C00);
        idle(8);
        chk("rep_count", 32'(n_out), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rep_data%0d", i), 32'(got_d[i]), 32'h4200);
            chk($sformatf("rep_col%0d", i), 32'(got_c[i]), 32'(i % 4));
            chk($sformatf("rep_row%0d", i), 32'(got_r[i]), 32'(i / 4));
        end
        chk("rep_ready_low", 32'(rlow), 32'd2);

        // mean-like scaling by 2^-1
        clear_log();
        scale_i = 4'd1;
        for (int c = 0; c < 4; c++) send(16'd2, 16'(c), 16'h3C00);
        idle(8);
        chk("scale1_count", 32'(n_out), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("scale1_data%0d", i), 32'(got_d[i]), 32'h3E00);

        // scale underflow to zero, single-pixel row
        clear_log();
        scale_i = 4'd15; width_i = 16'd1;
        send(16'd3, 16'd0, 16'h0400);
        idle(8);
        chk("scale15_count", 32'(n_out), 32'd1);
        chk("scale15_data", 32'(got_d[0]), 32'h0000);

        // width 1, replicate then zero pad
        clear_log();
        scale_i = 4'd0;
        send(16'd4, 16'd0, 16'h3800);
        idle(8);
        chk("w1_rep_count", 32'(n_out), 32'd1);
        chk("w1_rep_data", 32'(got_d[0]), 32'h3E00);
        chk("w1_rep_col", 32'(got_c[0]), 32'd0);
        chk("w1_rep_ready_low", 32'(rlow), 32'd1);
        clear_log();
        edge_mode_i = 1'b0;
        send(16'd5, 16'd0, 16'h3800);
        idle(8);
        chk("w1_zero_count", 32'(n_out), 32'd1);
        chk("w1_zero_data", 32'(got_d[0]), 32'h3800);

        // 5-tap instance with an infinity at col 1
        clear_log();
        sel5 = 1'b1; width_i = 16'd5;
        for (int c = 0; c < 5; c++) send(16'd6, 16'(c), px_w5[c]);
        idle(10);
        chk("w5_count", 32'(n_out), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("w5_data%0d", i), 32'(got_d[i]), 32'(exp_w5[i]));
            chk($sformatf("w5_col%0d", i), 32'(got_c[i]), 32'(i));
        end
        chk("w5_ready_low", 32'(rlow), 32'd2);
        sel5 = 1'b0;
        idle(1);

        // reset with beats in flight, stray mid-row beat, then a clean row
        width_i = 16'd4;
        for (int c = 0; c < 3; c++) send(16'd7, 16'(c), 16'h3C00);
        rst_i = 1'b1;
        clear_log();
        idle(1);
        rst_i = 1'b0;
        idle(10);
        chk("rst_no_output", 32'(n_out), 32'd0);
        clear_log();
        send(16'd8, 16'd2, 16'h4000);
        for (int c = 0; c < 4; c++) send(16'd8, 16'(c), 16'h3C00);
        idle(8);
        chk("post_rst_count", 32'(n_out), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("post_rst_data%0d", i), 32'(got_d[i]), 32'(exp_zero4[i]));
            chk($sformatf("post_rst_row%0d", i), 32'(got_r[i]), 32'd8);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
